pdm_duty_decoder: RTL and testbench
===================================

PDM_DUTY_DECODER -- requirements
Module: pdm_duty_decoder

Interface
REQ-001 Parameter WINDOW_LOG2, default 16: measurement window is 2^WINDOW_LOG2 clk cycles; legal range 4..24.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 pdm_in  input  1  pulse-density/PWM stream, asynchronous to clk (e.g. an LED driver line).
REQ-005 enable  input  1  high = measure continuously; low = idle.
REQ-006 duty  output  16  last measured duty, 0x0000 = always low, 0xFFFF = always high.
REQ-007 duty_valid  output  1  duty holds an unconsumed result.
REQ-008 duty_ready  input  1  consumer accepts duty when duty_valid && duty_ready.
REQ-009 overrun  output  1  sticky: a completed result was dropped.
REQ-010 clear_overrun  input  1  synchronous clear of overrun.

Function
REQ-011 pdm_in passes through a 2-flop synchronizer; only the synchronized bit is counted.
REQ-012 States: IDLE, FILL, COUNT; IDLE->FILL when enable=1; FILL lasts 2 cycles, then ->COUNT; any state ->IDLE when enable=0.
REQ-013 COUNT: ones counter (WINDOW_LOG2+1 bits) increments on each cycle with synchronized bit=1; window counter counts 0..2^WINDOW_LOG2-1.
REQ-014 At window counter terminal value the window closes; the next window starts the following cycle with no gap cycle and the ones counter restarted (including that cycle's sample).
REQ-015 Scaling: WINDOW_LOG2<16 -> ones << (16-WINDOW_LOG2); WINDOW_LOG2>=16 -> ones >> (WINDOW_LOG2-16); result >0xFFFF saturates to 0xFFFF.
REQ-016 Latency: duty and duty_valid update one cycle after the closing cycle.
REQ-017 duty_valid, once set, stays high and duty stays stable until a handshake cycle (valid && ready).
REQ-018 Window closes while duty_valid=1 and no handshake that cycle: new result discarded, duty unchanged, overrun set.
REQ-019 Window closes in the same cycle as a handshake: new result loaded, duty_valid stays high, no overrun.
REQ-020 enable low mid-window: partial counts discarded, no result produced; a pending duty_valid result is retained.
REQ-021 clear_overrun and an overrun event in the same cycle: overrun ends set (set wins).

Reset
REQ-022 reset_n low: state IDLE, counters 0, synchronizer 0, duty=0x0000, duty_valid=0, overrun=0, edge_count=0 (when present).
REQ-023 Reset mid-window aborts measurement; after release, measurement restarts from IDLE/FILL.

Configuration
REQ-024 Macro PDM_DUTY_EDGE_COUNT_EN defined: adds output edge_count (16 bits), number of synchronized rising edges in the window, saturating at 0xFFFF, loaded and held under exactly the same rules as duty.
REQ-025 Macro undefined: no edge_count port, no edge-detect logic; all other behaviour identical.

Structure
REQ-026 Shared package pdm_pkg holds DUTY_W=16, the state type (IDLE, FILL, COUNT) and the saturation constant 0xFFFF.
REQ-027 Synchronizer is the sub-module pdm_sync2 (2-flop, async active-low reset to 0); everything else is inline.

Verification (WINDOW_LOG2=8)
REQ-028 pdm_in held 1, enable=1, duty_ready=1 -> first duty=0xFFFF (256 ones saturated), duty_valid high 1 cycle after window close.
REQ-029 pdm_in 50% square wave, period 2 -> duty=0x8000 every 256 cycles; with macro, edge_count=128.
REQ-030 pdm_in held 0 -> duty=0x0000; duty_ready=0 across two window closes -> duty=first result, overrun=1; clear_overrun -> overrun=0.
REQ-031 Handshake in the same cycle as a window close -> new duty loaded, duty_valid stays 1, overrun stays 0.
REQ-032 enable dropped at cycle 100 of a window, re-raised 10 cycles later -> no result from the aborted window; next result after 2 FILL + 256 COUNT cycles.
REQ-033 reset_n pulsed low mid-window with duty_valid=1 -> all outputs 0 immediately (asynchronous), clean restart after release.

Source files
------------

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared widths, saturation constant and state type for the PDM duty decoder.
package pdm_pkg;
   localparam int DUTY_W = 16;
   localparam logic [DUTY_W-1:0] DUTY_MAX = 16'hFFFF;
   typedef enum logic [1:0] {IDLE, FILL, COUNT} state_t;
endpackage

// File: rtl/pdm_sync2.sv
// pdm_sync2: two-flop synchronizer with asynchronous active-low reset to 0.
module pdm_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   logic [1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[0], d};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) sync_q <= '0;
      else sync_q <= sync_d;
   assign q = sync_q[1];
endmodule

// File: rtl/pdm_duty_decoder.sv
// pdm_duty_decoder: measures the high-time fraction of pdm_in over 2^WINDOW_LOG2-cycle windows.
// Define PDM_DUTY_EDGE_COUNT_EN to add the edge_count output (rising edges per window).
module pdm_duty_decoder
   import pdm_pkg::*;
#(
   parameter int WINDOW_LOG2 = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pdm_in,
   input  logic              enable,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_valid,
   input  logic              duty_ready,
   output logic              overrun,
`ifdef PDM_DUTY_EDGE_COUNT_EN
   output logic [DUTY_W-1:0] edge_count,
`endif
   input  logic              clear_overrun
);
   localparam int OW  = WINDOW_LOG2 + 1;
   localparam int SW  = WINDOW_LOG2 + 17;
   localparam int SHL = (WINDOW_LOG2 < 16) ? 16 - WINDOW_LOG2 : 0;
   localparam int SHR = (WINDOW_LOG2 > 16) ? WINDOW_LOG2 - 16 : 0;
   state_t                 state_q, state_d;
   logic                   fill_q, fill_d;
   logic [WINDOW_LOG2-1:0] win_q, win_d;
   logic [OW-1:0]          ones_q, ones_d, ones_tot;
   logic [SW-1:0]          scaled;
   logic [DUTY_W-1:0]      duty_q, duty_d, duty_new;
   logic                   valid_q, valid_d, overrun_q, overrun_d;
   logic                   s, counting, close, hs, load;
   pdm_sync2 u_sync (.clk(clk), .reset_n(reset_n), .d(pdm_in), .q(s));
   always_comb begin
      counting  = enable && state_q == COUNT;
      close     = counting && &win_q;
      hs        = valid_q && duty_ready;
      load      = close && (!valid_q || hs);
      ones_tot  = ones_q + OW'(s);
      scaled    = (SW'(ones_tot) << SHL) >> SHR;
      duty_new  = (scaled > SW'(DUTY_MAX)) ? DUTY_MAX : scaled[DUTY_W-1:0];
      state_d   = !enable ? IDLE :
                  state_q == IDLE ? FILL :
                  (state_q == FILL && fill_q) ? COUNT : state_q;
      fill_d    = enable && state_q == FILL && !fill_q;
      win_d     = counting ? win_q + 1'b1 : '0;
      // closing cycle's sample goes into the result; the next window starts from zero
      ones_d    = (counting && !close) ? ones_tot : '0;
      duty_d    = load ? duty_new : duty_q;
      valid_d   = load || (valid_q && !hs);
      overrun_d = (close && valid_q && !hs) || (overrun_q && !clear_overrun);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q   <= IDLE;
         fill_q    <= 1'b0;
         win_q     <= '0;
         ones_q    <= '0;
         duty_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         win_q     <= win_d;
         ones_q    <= ones_d;
         duty_q    <= duty_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   assign duty       = duty_q;
   assign duty_valid = valid_q;
   assign overrun    = overrun_q;
`ifdef PDM_DUTY_EDGE_COUNT_EN
   logic              prev_q;
   logic [DUTY_W-1:0] edges_q, edges_d, edges_tot, edge_out_q, edge_out_d;
   always_comb begin
      edges_tot  = (edges_q == DUTY_MAX) ? DUTY_MAX : edges_q + DUTY_W'(s && !prev_q);
      edges_d    = (counting && !close) ? edges_tot : '0;
      edge_out_d = load ? edges_tot : edge_out_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         prev_q     <= 1'b0;
         edges_q    <= '0;
         edge_out_q <= '0;
      end else begin
         prev_q     <= s;
         edges_q    <= edges_d;
         edge_out_q <= edge_out_d;
      end
   assign edge_count = edge_out_q;
`endif
endmodule

// File: tb/tb_pdm_duty_decoder.sv
// tb_pdm_duty_decoder: directed table-driven bench for pdm_duty_decoder at WINDOW_LOG2=8.
module tb_pdm_duty_decoder;
   logic clk = 1'b0, reset_n = 1'b0, pdm_in = 1'b0, enable = 1'b0;
   logic duty_ready = 1'b0, clear_overrun = 1'b0;
   logic [15:0] duty;
   logic duty_valid, overrun;
`ifdef PDM_DUTY_EDGE_COUNT_EN
   logic [15:0] edge_count;
`endif
   logic [3:0] pat = 4'h0;
   int ph = 0;
   int total = 0, bad = 0;
   int n;
   typedef struct {
      logic [3:0]  pat;
      logic [15:0] duty;
      logic [15:0] edges;
   } vec_t;
   vec_t vt[5];

   pdm_duty_decoder #(.WINDOW_LOG2(8)) dut (
      .clk(clk), .reset_n(reset_n), .pdm_in(pdm_in), .enable(enable),
      .duty(duty), .duty_valid(duty_valid), .duty_ready(duty_ready),
      .overrun(overrun),
`ifdef PDM_DUTY_EDGE_COUNT_EN
      .edge_count(edge_count),
`endif
      .clear_overrun(clear_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      ph = (ph + 1) % 4;
      pdm_in = pat[ph];
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cnt);
      cnt = 0;
      do begin
         cyc(1);
         cnt++;
      end while (!duty_valid && cnt < 1000);
   endtask

   task automatic restart(input logic [3:0] p, input logic rdy, input string nm);
      int k;
      enable = 1'b0;
      duty_ready = 1'b1;
      clear_overrun = 1'b1;
      pat = p;
      cyc(1);
      clear_overrun = 1'b0;
      cyc(3);
      duty_ready = rdy;
      enable = 1'b1;
      wait_valid(k);
      chk({nm, "_latency"}, k, 259);
   endtask

   initial begin
      vt[0] = '{4'hF,    16'hFFFF, 16'd0};
      vt[1] = '{4'h0,    16'h0000, 16'd0};
      vt[2] = '{4'b0101, 16'h8000, 16'd128};
      vt[3] = '{4'b0001, 16'h4000, 16'd64};
      vt[4] = '{4'b0111, 16'hC000, 16'd64};

      cyc(3);
      chk("reset_duty", duty, 16'h0000);
      chk("reset_valid", duty_valid, 0);
      chk("reset_overrun", overrun, 0);
      reset_n = 1'b1;
      cyc(2);

      for (int i = 0; i < 5; i++) begin
         restart(vt[i].pat, 1'b1, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_duty", i), duty, vt[i].duty);
         chk($sformatf("vec%0d_valid", i), duty_valid, 1);
`ifdef PDM_DUTY_EDGE_COUNT_EN
         chk($sformatf("vec%0d_edges", i), edge_count, vt[i].edges);
`endif
         cyc(1);
         chk($sformatf("vec%0d_consumed", i), duty_valid, 0);
         wait_valid(n);
         chk($sformatf("vec%0d_period", i), n, 255);
         chk($sformatf("vec%0d_duty2", i), duty, vt[i].duty);
         chk($sformatf("vec%0d_overrun", i), overrun, 0);
      end

      // overrun: held result survives a second close, sticky flag, set wins over clear
      restart(4'hF, 1'b0, "ovr");
      chk("ovr_first_duty", duty, 16'hFFFF);
      pat = 4'h0;
      cyc(256);
      chk("ovr_flag", overrun, 1);
      chk("ovr_duty_held", duty, 16'hFFFF);
      chk("ovr_valid_held", duty_valid, 1);
      clear_overrun = 1'b1;
      cyc(1);
      clear_overrun = 1'b0;
      chk("ovr_cleared", overrun, 0);
      cyc(254);
      clear_overrun = 1'b1;
      cyc(1);
      clear_overrun = 1'b0;
      chk("ovr_set_wins", overrun, 1);
      clear_overrun = 1'b1;
      cyc(1);
      clear_overrun = 1'b0;
      chk("ovr_cleared2", overrun, 0);

      // handshake coincident with window close
      cyc(254);
      duty_ready = 1'b1;
      cyc(1);
      duty_ready = 1'b0;
      chk("hs_close_duty", duty, 16'h0000);
      chk("hs_close_valid", duty_valid, 1);
      chk("hs_close_overrun", overrun, 0);
      duty_ready = 1'b1;
      cyc(1);
      chk("hs_close_consumed", duty_valid, 0);

      // enable dropped mid-window keeps pending result and discards partial counts
      restart(4'b0101, 1'b0, "abort");
      chk("abort_first_duty", duty, 16'h8000);
      cyc(100);
      enable = 1'b0;
      pat = 4'h0;
      cyc(10);
      chk("abort_valid_kept", duty_valid, 1);
      chk("abort_duty_kept", duty, 16'h8000);
      chk("abort_overrun", overrun, 0);
      duty_ready = 1'b1;
      cyc(1);
      chk("abort_consumed", duty_valid, 0);
      enable = 1'b1;
      wait_valid(n);
      chk("abort_relatency", n, 259);
      chk("abort_new_duty", duty, 16'h0000);

      // asynchronous reset mid-window with a pending result
      restart(4'hF, 1'b0, "rst");
      chk("rst_pre_valid", duty_valid, 1);
      cyc(50);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_duty", duty, 16'h0000);
      chk("rst_async_valid", duty_valid, 0);
      chk("rst_async_overrun", overrun, 0);
      cyc(2);
      chk("rst_hold_valid", duty_valid, 0);
      reset_n = 1'b1;
      wait_valid(n);
      chk("rst_restart_latency", n, 259);
      chk("rst_restart_duty", duty, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
